// File: rtl/switch_pio_pkg.sv
// switch_pio_pkg: register offsets, edge-mode encodings and sizing helper for the switch PIO
package switch_pio_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
    function automatic int cnt_width(int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: 2-flop synchronizer followed by an optional stable-count debouncer
module pio_debounce
    import switch_pio_pkg::*;
#(
    parameter int N = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);
    localparam int CW = cnt_width(N);
    logic [1:0] sync;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync <= '0;
        else sync <= {sync[0], din};
    if (N == 0) begin : g_bypass
        assign dout = sync[1];
    end else begin : g_debounce
        logic deb;
        logic [CW-1:0] cnt;
        // the count reaching N is the Nth differing cycle, so the update fires at N-1
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                deb <= 1'b0;
                cnt <= '0;
            end else if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(N - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        assign dout = deb;
    end
endmodule

// File: rtl/switch_pio_edge.sv
// switch_pio_edge: debounced switch PIO with edge capture and maskable level interrupt
module switch_pio_edge
    import switch_pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] data, prev, edgecap, irqmask, edges, clr;
    logic [31:0] rd_mux;
    logic wr;
    logic unused_wd;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(.N(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .dout   (data[i])
        );
    end
    assign wr = chipselect & ~write_n;
    assign unused_wd = ^writedata;
    always_comb begin
        edges  = EDGE_TYPE == EDGE_FALLING ? prev & ~data :
                 EDGE_TYPE == EDGE_ANY     ? prev ^ data  : data & ~prev;
        clr    = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        rd_mux = 32'(address == ADDR_DATA    ? data    :
                      address == ADDR_IRQMASK ? irqmask :
                      address == ADDR_EDGECAP ? edgecap : '0);
    end
    // OR-ing edges after the clear lets a same-cycle edge win over W1C
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prev     <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            prev     <= data;
            edgecap  <= (edgecap & ~clr) | edges;
            readdata <= rd_mux;
            if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
        end
    assign irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_switch_pio_edge.sv
// tb_switch_pio_edge: directed scoreboard bench for bypass, debounce and falling-edge configurations
module tb_switch_pio_edge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] address = '0;
    logic [2:0] cs = '0;
    logic write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [2:0] in0 = '0, in1 = '0, in2 = '0;
    logic [31:0] rd0, rd1, rd2;
    logic irq0, irq1, irq2;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    switch_pio_edge u_byp (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0)
    );
    switch_pio_edge #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1)
    );
    switch_pio_edge #(.WIDTH(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string tag);
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick(1);
        check(tag_q.pop_front(), d == 0 ? rd0 : d == 1 ? rd1 : rd2, exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] data);
        cs = sel;
        write_n = 1'b0;
        address = a;
        writedata = data;
        tick(1);
        cs = '0;
        write_n = 1'b1;
        writedata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("reset_rd0", rd0, 32'h0);
        check("reset_rd1", rd1, 32'h0);
        check("reset_irq", {29'b0, irq2, irq1, irq0}, 32'h0);
        reset_n = 1'b1;
        tick(2);
        // bypass: data visible in readdata at the third edge after the change
        in0 = 3'b101;
        rd(0, 2'd0, 32'h0, "byp_e1");
        rd(0, 2'd0, 32'h0, "byp_e2");
        rd(0, 2'd0, 32'h5, "byp_e3");
        rd(0, 2'd3, 32'h5, "byp_edgecap");
        check("byp_irq_masked", {31'b0, irq0}, 32'h0);
        wr(3'b001, 2'd2, 32'h1);
        check("mask_irq_on", {31'b0, irq0}, 32'h1);
        wr(3'b001, 2'd3, 32'h1);
        check("w1c_irq_off", {31'b0, irq0}, 32'h0);
        rd(0, 2'd3, 32'h4, "w1c_edgecap");
        wr(3'b001, 2'd2, 32'hFFFF_FFFC);
        check("mask2_irq_on", {31'b0, irq0}, 32'h1);
        rd(0, 2'd2, 32'h4, "irqmask_rd");
        rd(0, 2'd1, 32'h0, "rsvd_rd");
        wr(3'b001, 2'd0, 32'hFFFF_FFFF);
        rd(0, 2'd0, 32'h5, "data_wr_ignored");
        wr(3'b000, 2'd2, 32'h0);
        rd(0, 2'd2, 32'h4, "no_cs_ignored");
        // collision: W1C lands on the same edge that captures bit 2
        in0 = 3'b001;
        tick(4);
        wr(3'b001, 2'd3, 32'h7);
        rd(0, 2'd3, 32'h0, "pre_collision");
        in0 = 3'b101;
        tick(2);
        wr(3'b001, 2'd3, 32'h4);
        rd(0, 2'd3, 32'h4, "collision_set_wins");
        check("collision_irq", {31'b0, irq0}, 32'h1);
        // debounce: 3-cycle glitch rejected
        in1 = 3'b001;
        tick(3);
        in1 = 3'b000;
        tick(8);
        rd(1, 2'd0, 32'h0, "glitch_data");
        rd(1, 2'd3, 32'h0, "glitch_edge");
        in1 = 3'b001;
        for (int k = 1; k <= 6; k++) rd(1, 2'd0, 32'h0, $sformatf("deb_hold_e%0d", k));
        rd(1, 2'd0, 32'h1, "deb_hold_e7");
        rd(1, 2'd3, 32'h1, "deb_edgecap");
        // falling mode
        in2 = 3'b010;
        tick(5);
        rd(2, 2'd3, 32'h0, "fall_rise_ignored");
        in2 = 3'b000;
        tick(5);
        rd(2, 2'd3, 32'h2, "fall_captured");
        // reset in the middle of a debounce count
        in1 = 3'b111;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("rst_rd0", rd0, 32'h0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_irq", {29'b0, irq2, irq1, irq0}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        rd(1, 2'd3, 32'h0, "rel_edgecap");
        rd(1, 2'd2, 32'h0, "rel_irqmask");
        for (int k = 3; k <= 6; k++) rd(1, 2'd0, 32'h0, $sformatf("rel_data_e%0d", k));
        rd(1, 2'd0, 32'h7, "rel_data_e7");
        rd(1, 2'd3, 32'h7, "rel_edgecap_final");
        check("rel_irq", {31'b0, irq1}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
